// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED driver.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_GREEN = 1;
  localparam int unsigned CH_BLUE  = 2;

  // Counter width for a wrap limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rgb_led_channel.sv
// One LED channel: shadow/active config, breathe ramp FSM, duty select and PWM compare.
module rgb_led_channel
  import rgb_led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                frame_last,
  input  logic                step_tick,
  input  logic                blink_phase,
  input  logic                wr_en,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic                led_n
);

  mode_e               shd_mode_q, shd_mode_d;
  logic [PWM_BITS-1:0] shd_level_q, shd_level_d;
  mode_e               act_mode_q, act_mode_d;
  logic [PWM_BITS-1:0] act_level_q, act_level_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  dir_e                dir_q, dir_d;
  logic                led_n_q, led_n_d;
  logic [PWM_BITS-1:0] duty;

  always_comb begin
    shd_mode_d  = shd_mode_q;
    shd_level_d = shd_level_q;
    act_mode_d  = act_mode_q;
    act_level_d = act_level_q;
    ramp_d      = ramp_q;
    dir_d       = dir_q;

    if (wr_en) begin
      shd_mode_d  = mode_e'(wr_mode);
      shd_level_d = wr_level;
    end

    // Loading from the _d shadow forwards a write landing on the boundary cycle.
    if (frame_last) begin
      act_mode_d  = shd_mode_d;
      act_level_d = shd_level_d;
      if (act_mode_d == MODE_BREATHE) begin
        if (act_mode_q != MODE_BREATHE) begin
          ramp_d = '0;
          dir_d  = DIR_UP;
        end else if (act_level_d < ramp_q) begin
          ramp_d = act_level_d;
          dir_d  = DIR_DOWN;
        end else if (step_tick) begin
          unique case (dir_q)
            DIR_UP: begin
              if (ramp_q < act_level_d) ramp_d = ramp_q + 1'b1;
              else                      dir_d  = DIR_DOWN;
            end
            DIR_DOWN: begin
              if (ramp_q != '0) ramp_d = ramp_q - 1'b1;
              else              dir_d  = DIR_UP;
            end
          endcase
        end
      end
    end

    unique case (act_mode_q)
      MODE_OFF:     duty = '0;
      MODE_ON:      duty = act_level_q;
      MODE_BLINK:   duty = blink_phase ? act_level_q : '0;
      MODE_BREATHE: duty = ramp_q;
    endcase

    led_n_d = ~(pwm_cnt < duty);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shd_mode_q  <= MODE_OFF;
      shd_level_q <= '0;
      act_mode_q  <= MODE_OFF;
      act_level_q <= '0;
      ramp_q      <= '0;
      dir_q       <= DIR_UP;
      led_n_q     <= 1'b1;
    end else begin
      shd_mode_q  <= shd_mode_d;
      shd_level_q <= shd_level_d;
      act_mode_q  <= act_mode_d;
      act_level_q <= act_level_d;
      ramp_q      <= ramp_d;
      dir_q       <= dir_d;
      led_n_q     <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule

// File: rtl/rgb_led_ctrl.sv
// Multi-channel active-low LED driver: shared PWM/blink/step timebase plus per-channel logic.
module rgb_led_ctrl
  import rgb_led_pkg::*;
#(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned BLINK_FRAMES = 23438,
  parameter int unsigned STEP_FRAMES  = 92
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [PWM_BITS-1:0]         cfg_level,
  output logic                        frame_end,
  output logic [CHANNELS-1:0]         led_n
);

  localparam int unsigned CH_W = $clog2(CHANNELS);
  localparam int unsigned BW   = cnt_width(BLINK_FRAMES);
  localparam int unsigned SW   = cnt_width(STEP_FRAMES);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                frame_end_q, frame_end_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic                frame_last;
  logic                step_wrap;
  logic                step_tick;
  logic [CHANNELS-1:0] wr_en;

  always_comb begin
    frame_last    = (pwm_cnt_q == '1);
    step_wrap     = (step_cnt_q == SW'(STEP_FRAMES - 1));
    step_tick     = frame_last && step_wrap;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    frame_end_d   = frame_last;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    step_cnt_d    = step_cnt_q;

    if (frame_last) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      if (step_wrap) step_cnt_d = '0;
      else           step_cnt_d = step_cnt_q + 1'b1;
    end

    // Out-of-range channel numbers match no decode line and are dropped.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_en[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      frame_end_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      frame_end_q   <= frame_end_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign frame_end = frame_end_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rgb_led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .pwm_cnt     (pwm_cnt_q),
      .frame_last  (frame_last),
      .step_tick   (step_tick),
      .blink_phase (blink_phase_q),
      .wr_en       (wr_en[g]),
      .wr_mode     (cfg_mode),
      .wr_level    (cfg_level),
      .led_n       (led_n[g])
    );
  end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Directed self-checking bench for rgb_led_ctrl with short blink/step periods.
module tb_rgb_led_ctrl;
  import rgb_led_pkg::*;

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cfg_we    = 1'b0;
  logic [1:0] cfg_ch    = '0;
  logic [1:0] cfg_mode  = '0;
  logic [7:0] cfg_level = '0;
  logic       frame_end;
  logic [2:0] led_n;

  int errors = 0;
  int checks = 0;
  int frame_idx = 0;
  int nwr = 0;
  int wr_at[4];
  int wr_ch[4];
  int wr_mode[4];
  int wr_lvl[4];
  int r1[12] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1};

  always #5 clk_in = ~clk_in;

  rgb_led_ctrl #(
    .CHANNELS     (3),
    .PWM_BITS     (8),
    .BLINK_FRAMES (2),
    .STEP_FRAMES  (1)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_level (cfg_level),
    .frame_end (frame_end),
    .led_n     (led_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bl(input int k, input int lvl);
    return (((k / 2) % 2) == 1) ? lvl : 0;
  endfunction

  task automatic sched(input int at, input int ch, input int mode, input int lvl);
    wr_at[nwr]   = at;
    wr_ch[nwr]   = ch;
    wr_mode[nwr] = mode;
    wr_lvl[nwr]  = lvl;
    nwr++;
  endtask

  task automatic wait_frame_end(output int n);
    n = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk_in);
      if (frame_end === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  // Starts on the negedge where frame_end is high; counts lit clocks of one frame.
  task automatic run_frame(input int x0, input int x1, input int x2);
    int   lit[3];
    int   fe_cnt;
    logic fe_last;
    lit     = '{0, 0, 0};
    fe_cnt  = 0;
    fe_last = 1'b0;
    for (int j = 0; j < 256; j++) begin
      cfg_we = 1'b0;
      for (int s = 0; s < nwr; s++) begin
        if (wr_at[s] == j) begin
          cfg_we    = 1'b1;
          cfg_ch    = 2'(wr_ch[s]);
          cfg_mode  = 2'(wr_mode[s]);
          cfg_level = 8'(wr_lvl[s]);
        end
      end
      @(negedge clk_in);
      for (int c = 0; c < 3; c++) if (led_n[c] === 1'b0) lit[c]++;
      if (frame_end === 1'b1) fe_cnt++;
      fe_last = frame_end;
    end
    cfg_we = 1'b0;
    nwr    = 0;
    check($sformatf("f%0d_ch0", frame_idx), lit[0], x0);
    check($sformatf("f%0d_ch1", frame_idx), lit[1], x1);
    check($sformatf("f%0d_ch2", frame_idx), lit[2], x2);
    check($sformatf("f%0d_frame_end", frame_idx), 32'((fe_cnt == 1) && (fe_last === 1'b1)), 1);
    frame_idx++;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    check("rst_led_n", 32'(led_n), 32'h7);
    check("rst_frame_end", 32'(frame_end), 0);
    rst_n = 1'b1;
    wait_frame_end(n);
    check("first_frame_len", n, 256);
    frame_idx = 1;

    repeat (3) run_frame(0, 0, 0);

    sched(100, CH_RED, MODE_ON, 64);
    run_frame(0, 0, 0);
    repeat (2) run_frame(64, 0, 0);

    sched(100, CH_BLUE, MODE_BLINK, 255);
    run_frame(64, 0, 0);
    repeat (5) run_frame(64, 0, bl(frame_idx, 255));

    sched(100, CH_GREEN, MODE_BLINK, 128);
    run_frame(64, 0, bl(frame_idx, 255));
    repeat (4) run_frame(64, bl(frame_idx, 128), bl(frame_idx, 255));

    sched(100, CH_GREEN, MODE_BREATHE, 4);
    run_frame(64, bl(frame_idx, 128), bl(frame_idx, 255));
    for (int i = 0; i < 12; i++) begin
      if (i == 11) sched(100, CH_GREEN, MODE_BREATHE, 20);
      run_frame(64, r1[i], bl(frame_idx, 255));
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) sched(100, CH_GREEN, MODE_BREATHE, 5);
      run_frame(64, i + 2, bl(frame_idx, 255));
    end
    for (int i = 0; i < 3; i++) run_frame(64, 5 - i, bl(frame_idx, 255));

    sched(100, 3, MODE_ON, 200);
    run_frame(64, 2, bl(frame_idx, 255));
    run_frame(64, 1, bl(frame_idx, 255));

    sched(100, CH_GREEN, MODE_ON, 100);
    sched(102, CH_BLUE, MODE_ON, 200);
    run_frame(64, 0, bl(frame_idx, 255));
    sched(255, CH_RED, MODE_ON, 32);
    run_frame(64, 100, 200);
    sched(50, CH_BLUE, MODE_ON, 10);
    sched(150, CH_BLUE, MODE_ON, 50);
    run_frame(32, 100, 200);
    run_frame(32, 100, 50);

    repeat (20) @(negedge clk_in);
    check("pre_rst_led_n", 32'(led_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led_n", 32'(led_n), 32'h7);
    check("async_rst_frame_end", 32'(frame_end), 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    wait_frame_end(n);
    check("rerst_frame_len", n, 256);
    frame_idx = 1;
    repeat (2) run_frame(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
